store_buffer: RTL and testbench
===============================

STORE_BUFFER -- requirements
Module: store_buffer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning number of entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL have port st_valid  input  1  store request from the memory stage.
REQ-005 SHALL have port st_addr  input  32  store byte address; bits [1:0] ignored.
REQ-006 SHALL have port st_data  input  32  store word.
REQ-007 SHALL have port st_pc  input  32  PC of the store instruction.
REQ-008 SHALL have port st_ready  output  1  buffer can accept a store this cycle.
REQ-009 SHALL have port ld_valid  input  1  load lookup request.
REQ-010 SHALL have port ld_addr  input  32  load byte address; bits [1:0] ignored.
REQ-011 SHALL have port ld_hit  output  1  load address matches a buffered store.
REQ-012 SHALL have port ld_data  output  32  forwarded word, valid when ld_hit=1.
REQ-013 SHALL have port ld_stall  output  1  load must be held this cycle.
REQ-014 SHALL have port dm_ready  input  1  data memory accepts a write this cycle.
REQ-015 SHALL have ports dm_we (1), dm_addr (32), dm_wd (32) and dm_pc (32), all outputs, forming the write port to the data memory.
REQ-016 SHALL have port count  output  clog2(DEPTH)+1  number of occupied entries.

Function
- REQ-017 SHALL be a FIFO of {addr[31:2], data, pc} entries with read pointer, write pointer and count registers; pointers wrap modulo DEPTH.
- REQ-018 SHALL assert st_ready = (count != DEPTH).
- REQ-019 SHALL perform a push on a clock edge when st_valid && st_ready, writing the entry at the write pointer.
- REQ-020 SHALL drive dm_we = (count != 0) && dm_ready, combinationally, with dm_addr = {head.addr, 2'b00}, dm_wd = head.data and dm_pc = head.pc.
- REQ-021 SHALL pop the head on every edge where dm_we = 1.
- REQ-022 SHALL apply a simultaneous push and pop in the same edge, leaving count unchanged.
- REQ-023 SHALL NOT pass a store through in the cycle it arrives; minimum latency is st_valid accepted at edge N, dm_we = 1 in cycle N+1.
- REQ-024 SHALL reject a push when full (st_ready = 0), even if a pop occurs in the same cycle.
- REQ-025 SHALL drain stores to the data memory in strict FIFO order.
- REQ-026 SHALL hold dm_addr, dm_wd and dm_pc stable while dm_ready = 0.
- REQ-027 SHALL perform load matching against valid entries only, comparing bits [31:2]; an entry being popped in the current cycle still counts as a match.
- REQ-028 SHALL NOT match the store presented on st_* in the same cycle as the load.
- REQ-029 SHALL drive ld_hit = 0, ld_data = 0 and ld_stall = 0 when ld_valid = 0.

Reset
- REQ-030 SHALL, on an edge with reset = 1, clear count and both pointers; pending entries are discarded and never written to memory.
- REQ-031 SHALL give reset priority over a simultaneous push or pop.
- REQ-032 SHALL leave dm_we = 0, st_ready = 1 and count = 0 in the cycle after reset.
- REQ-033 SHALL drive dm_addr, dm_wd and dm_pc to 0 while empty.

Configuration
- REQ-034 SHALL use macro STORE_BUF_FWD_EN to select load forwarding.
- REQ-035 SHALL, when STORE_BUF_FWD_EN is defined, set ld_hit = 1 on any match, set ld_data to the data of the youngest matching entry, and keep ld_stall = 0.
- REQ-036 SHALL, when STORE_BUF_FWD_EN is undefined, tie ld_hit = 0 and ld_data = 0, and set ld_stall = ld_valid && any match, so that the load waits until the matching entries drain.

Verification
- REQ-037 SHALL cover: reset, push addr 0x10 data 0xAAAA5555 with dm_ready = 1 -> next cycle dm_we = 1, dm_addr = 0x10, dm_wd = 0xAAAA5555; count returns to 0.
- REQ-038 SHALL cover: dm_ready = 0, push 4 stores to 0x0/0x4/0x8/0xC -> count = 4, st_ready = 0; a 5th push is ignored; dm_ready = 1 -> writes drain in order over 4 cycles.
- REQ-039 SHALL cover, with STORE_BUF_FWD_EN: push 0x20 <= 1, then 0x20 <= 2, dm_ready = 0, load 0x23 -> ld_hit = 1, ld_data = 2.
- REQ-040 SHALL cover, without STORE_BUF_FWD_EN: the same sequence -> ld_stall = 1 until both entries drain, then ld_stall = 0.
- REQ-041 SHALL cover: full buffer, push and pop in the same cycle -> push rejected, count = 3 afterwards.
- REQ-042 SHALL cover: 3 entries pending, assert reset -> no further dm_we, count = 0, and a load to a previously buffered address shows ld_hit = 0 and ld_stall = 0.

Source files
------------

// File: rtl/store_buffer.sv
// Store buffer: FIFO of pending stores drained to data memory, with load address matching.
// Define STORE_BUF_FWD_EN to forward the youngest matching store to loads; otherwise matching loads stall.
module store_buffer #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        st_valid,
   input  logic [31:0] st_addr,
   input  logic [31:0] st_data,
   input  logic [31:0] st_pc,
   output logic        st_ready,
   input  logic        ld_valid,
   input  logic [31:0] ld_addr,
   output logic        ld_hit,
   output logic [31:0] ld_data,
   output logic        ld_stall,
   input  logic        dm_ready,
   output logic        dm_we,
   output logic [31:0] dm_addr,
   output logic [31:0] dm_wd,
   output logic [31:0] dm_pc,
   output logic [$clog2(DEPTH):0] count
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH) + 1;

   logic [29:0]   addr_mem [DEPTH];
   logic [31:0]   data_mem [DEPTH];
   logic [31:0]   pc_mem   [DEPTH];
   logic [PW-1:0] rd_ptr;
   logic [PW-1:0] wr_ptr;
   logic [CW-1:0] cnt;

   logic          full;
   logic          empty;
   logic          push;
   logic          pop;
   logic          match_any;
   logic [31:0]   match_data;

   // Byte-offset bits of both addresses are deliberately ignored.
   wire unused_low = &{1'b0, st_addr[1:0], ld_addr[1:0]};

   assign full     = (cnt == CW'(DEPTH));
   assign empty    = (cnt == '0);
   assign st_ready = !full;
   assign push     = st_valid && !full;
   assign dm_we    = !empty && dm_ready;
   assign pop      = dm_we;
   assign count    = cnt;

   assign dm_addr  = empty ? 32'h0 : {addr_mem[rd_ptr], 2'b00};
   assign dm_wd    = empty ? 32'h0 : data_mem[rd_ptr];
   assign dm_pc    = empty ? 32'h0 : pc_mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   cnt <= cnt + CW'(1);
            2'b01:   cnt <= cnt - CW'(1);
            default: cnt <= cnt;
         endcase
      end
   end

   // Entry storage carries no reset: occupancy is tracked by the pointers and count.
   always_ff @(posedge clk) begin
      if (!reset && push) begin
         addr_mem[wr_ptr] <= st_addr[31:2];
         data_mem[wr_ptr] <= st_data;
         pc_mem[wr_ptr]   <= st_pc;
      end
   end

   // Walk oldest to youngest so the last match seen is the youngest store.
   always_comb begin
      match_any  = 1'b0;
      match_data = 32'h0;
      for (int k = 0; k < DEPTH; k++) begin
         if ((CW'(k) < cnt) && (addr_mem[rd_ptr + PW'(k)] == ld_addr[31:2])) begin
            match_any  = 1'b1;
            match_data = data_mem[rd_ptr + PW'(k)];
         end
      end
   end

`ifdef STORE_BUF_FWD_EN
   assign ld_hit   = ld_valid && match_any;
   assign ld_data  = ld_hit ? match_data : 32'h0;
   assign ld_stall = 1'b0;
`else
   wire unused_fwd = &{1'b0, match_data};
   assign ld_hit   = 1'b0;
   assign ld_data  = 32'h0;
   assign ld_stall = ld_valid && match_any;
`endif

endmodule

// File: tb/tb_store_buffer.sv
// Self-checking bench for store_buffer: directed scenarios plus random traffic against a queue model.
module tb_store_buffer;

   localparam int DEPTH = 4;
   localparam int CW    = $clog2(DEPTH) + 1;

   logic        clk = 1'b0;
   logic        reset;
   logic        st_valid;
   logic [31:0] st_addr;
   logic [31:0] st_data;
   logic [31:0] st_pc;
   logic        st_ready;
   logic        ld_valid;
   logic [31:0] ld_addr;
   logic        ld_hit;
   logic [31:0] ld_data;
   logic        ld_stall;
   logic        dm_ready;
   logic        dm_we;
   logic [31:0] dm_addr;
   logic [31:0] dm_wd;
   logic [31:0] dm_pc;
   logic [CW-1:0] count;

   int vectors = 0;
   int errors  = 0;
   bit mon_en  = 1'b0;

   // Expected stores in drain order: {addr(word-aligned), data, pc}.
   logic [95:0] exp_q[$];

   store_buffer #(.DEPTH(DEPTH)) dut (
      .clk(clk), .reset(reset),
      .st_valid(st_valid), .st_addr(st_addr), .st_data(st_data), .st_pc(st_pc), .st_ready(st_ready),
      .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_hit(ld_hit), .ld_data(ld_data), .ld_stall(ld_stall),
      .dm_ready(dm_ready), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wd(dm_wd), .dm_pc(dm_pc),
      .count(count)
   );

   // ---------------- clock / reset ----------------
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   // ---------------- checking ----------------
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_load(input string tag, input bit match, input logic [31:0] data);
`ifdef STORE_BUF_FWD_EN
      check({tag, "_hit"},   32'(ld_hit),   32'(match));
      check({tag, "_data"},  ld_data,       match ? data : 32'h0);
      check({tag, "_stall"}, 32'(ld_stall), 32'h0);
`else
      check({tag, "_hit"},   32'(ld_hit),   32'h0);
      check({tag, "_data"},  ld_data,       32'h0);
      check({tag, "_stall"}, 32'(ld_stall), 32'(match));
`endif
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_store(input logic [31:0] a, input logic [31:0] d, input logic [31:0] p);
      st_valid = 1'b1;
      st_addr  = a;
      st_data  = d;
      st_pc    = p;
      tick();
      st_valid = 1'b0;
   endtask

   // ---------------- scoreboard / monitor ----------------
   always @(negedge clk) begin
      int          sz;
      bit          exp_we;
      bit          m_hit;
      logic [31:0] m_data;
      if (reset) begin
         exp_q.delete();
      end else if (mon_en) begin
         sz     = exp_q.size();
         exp_we = (sz != 0) && dm_ready;
         check("sb_dm_we",    32'(dm_we),    32'(exp_we));
         check("sb_count",    32'(count),    32'(sz));
         check("sb_st_ready", 32'(st_ready), 32'(sz != DEPTH));
         if (sz != 0) begin
            check("sb_dm_addr", dm_addr, exp_q[0][95:64]);
            check("sb_dm_wd",   dm_wd,   exp_q[0][63:32]);
            check("sb_dm_pc",   dm_pc,   exp_q[0][31:0]);
         end else begin
            check("sb_empty_addr", dm_addr, 32'h0);
            check("sb_empty_wd",   dm_wd,   32'h0);
            check("sb_empty_pc",   dm_pc,   32'h0);
         end
         m_hit  = 1'b0;
         m_data = 32'h0;
         for (int i = 0; i < sz; i++) begin
            if (exp_q[i][95:66] == ld_addr[31:2]) begin
               m_hit  = 1'b1;
               m_data = exp_q[i][63:32];
            end
         end
         check_load("sb_ld", ld_valid && m_hit, m_data);
         if (exp_we) void'(exp_q.pop_front());
         if (st_valid && sz != DEPTH) exp_q.push_back({st_addr[31:2], 2'b00, st_data, st_pc});
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      reset    = 1'b1;
      st_valid = 1'b0;
      st_addr  = '0;
      st_data  = '0;
      st_pc    = '0;
      ld_valid = 1'b0;
      ld_addr  = '0;
      dm_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset    = 1'b0;
      dm_ready = 1'b1;
      mon_en   = 1'b1;

      @(negedge clk);
      check("rst_count",    32'(count),    32'h0);
      check("rst_st_ready", 32'(st_ready), 32'h1);
      check("rst_dm_we",    32'(dm_we),    32'h0);
      tick();

      // Single store: no same-cycle passthrough, written the next cycle.
      st_valid = 1'b1; st_addr = 32'h10; st_data = 32'hAAAA5555; st_pc = 32'h400;
      @(negedge clk);
      check("single_no_pass", 32'(dm_we), 32'h0);
      tick();
      st_valid = 1'b0;
      @(negedge clk);
      check("single_we",   32'(dm_we), 32'h1);
      check("single_addr", dm_addr,    32'h10);
      check("single_wd",   dm_wd,      32'hAAAA5555);
      tick();
      @(negedge clk);
      check("single_count0", 32'(count), 32'h0);
      tick();

      // Fill with memory stalled, fifth push must be ignored, then drain in order.
      dm_ready = 1'b0;
      for (int i = 0; i < 5; i++) push_store(32'(i * 4) + ((i == 4) ? 32'h100 : 32'h0), $urandom, 32'h1000 + 32'(i));
      @(negedge clk);
      check("fill_count",    32'(count),    32'h4);
      check("fill_st_ready", 32'(st_ready), 32'h0);
      tick();
      dm_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("drain_we",   32'(dm_we), 32'h1);
         check("drain_addr", dm_addr,    32'(i * 4));
         tick();
      end
      @(negedge clk);
      check("drain_count0", 32'(count), 32'h0);
      tick();

      // Two stores to the same word, load at an unaligned byte of it.
      dm_ready = 1'b0;
      push_store(32'h20, 32'h1, 32'h2000);
      push_store(32'h20, 32'h2, 32'h2004);
      ld_valid = 1'b1;
      ld_addr  = 32'h23;
      @(negedge clk);
      check_load("fwd_held", 1'b1, 32'h2);
      tick();
      dm_ready = 1'b1;
      @(negedge clk);
      check_load("fwd_pop0", 1'b1, 32'h2);
      tick();
      @(negedge clk);
      check_load("fwd_pop1", 1'b1, 32'h2);
      tick();
      @(negedge clk);
      check_load("fwd_drained", 1'b0, 32'h0);
      ld_valid = 1'b0;
      tick();

      // Full buffer with push and pop together: push rejected.
      dm_ready = 1'b0;
      for (int i = 0; i < 4; i++) push_store(32'h40 + 32'(i * 4), 32'h50 + 32'(i), 32'h3000);
      st_valid = 1'b1; st_addr = 32'h200; st_data = 32'hDEAD; st_pc = 32'h3010;
      dm_ready = 1'b1;
      @(negedge clk);
      check("full_pp_st_ready", 32'(st_ready), 32'h0);
      check("full_pp_dm_we",    32'(dm_we),    32'h1);
      tick();
      st_valid = 1'b0;
      dm_ready = 1'b0;
      @(negedge clk);
      check("full_pp_count3", 32'(count), 32'h3);
      tick();

      // Reset with three entries pending discards them.
      reset = 1'b1;
      tick();
      reset    = 1'b0;
      dm_ready = 1'b1;
      ld_valid = 1'b1;
      ld_addr  = 32'h48;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         check("rst_pend_we",    32'(dm_we), 32'h0);
         check("rst_pend_count", 32'(count), 32'h0);
         check_load("rst_pend_ld", 1'b0, 32'h0);
         tick();
      end
      ld_valid = 1'b0;

      // Random traffic over a small address window so loads often match.
      for (int n = 0; n < 400; n++) begin
         st_valid = 1'($urandom_range(0, 1));
         st_addr  = 32'h80 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
         st_data  = $urandom;
         st_pc    = $urandom;
         dm_ready = ($urandom_range(0, 3) != 0);
         ld_valid = 1'($urandom_range(0, 1));
         ld_addr  = 32'h80 + 32'($urandom_range(0, 7) * 4) + 32'($urandom_range(0, 3));
         if ($urandom_range(0, 99) == 0) reset = 1'b1;
         tick();
         reset = 1'b0;
      end

      st_valid = 1'b0;
      ld_valid = 1'b0;
      dm_ready = 1'b1;
      for (int i = 0; i < 20 && exp_q.size() != 0; i++) tick();
      @(negedge clk);
      check("final_count0", 32'(count), 32'h0);
      check("final_model_empty", 32'(exp_q.size()), 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
